// File: rtl/fft_peak_pkg.sv
// Shared definitions for the FFT peak finder: sweep FSM states and default sizing.
// Defaults describe a 1024-bin, 16-bit magnitude spectrum with a 2-bin window.
package fft_peak_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_WIN_LEN = 2;
    localparam int DEF_RD_LAT  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/fft_peak_finder_window_sum.sv
// Sliding-window accumulator: a WIN_LEN-deep delay line plus a running sum.
// o_sum_next is the sum including the current sample, so the caller can compare it in the same cycle.
module window_sum
    import fft_peak_pkg::*;
#(
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int WIN_LEN = DEF_WIN_LEN,
    localparam int SUM_W   = DATA_W + $clog2(WIN_LEN)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic [SUM_W-1:0]  o_sum_next
);

    logic [DATA_W-1:0] r_taps [WIN_LEN];
    logic [SUM_W-1:0]  r_sum;

    // The oldest tap is always part of r_sum, so the subtraction never underflows.
    always_comb begin
        o_sum_next = r_sum + SUM_W'(i_data) - SUM_W'(r_taps[WIN_LEN-1]);
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sum <= '0;
            for (int i = 0; i < WIN_LEN; i++) begin
                r_taps[i] <= '0;
            end
        end else if (i_valid) begin
            r_sum     <= o_sum_next;
            r_taps[0] <= i_data;
            for (int i = 1; i < WIN_LEN; i++) begin
                r_taps[i] <= r_taps[i-1];
            end
        end
    end

endmodule

// File: rtl/fft_peak_finder.sv
// Sweeps a bin range of a spectrum memory and reports the window of WIN_LEN bins with the
// largest magnitude sum; ties keep the lowest ending bin.
module fft_peak_finder
    import fft_peak_pkg::*;
#(
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int ADDR_W  = DEF_ADDR_W,
    parameter  int WIN_LEN = DEF_WIN_LEN,
    parameter  int RD_LAT  = DEF_RD_LAT,
    localparam int SUM_W   = DATA_W + $clog2(WIN_LEN)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] lo_bin,
    input  logic [ADDR_W-1:0] hi_bin,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [SUM_W-1:0]  peak_sum,
    output logic              peak_valid
);

    localparam int ELIG_W = ADDR_W + 5;

    state_t            r_state;
    logic [ADDR_W-1:0] r_lo;
    logic [ADDR_W-1:0] r_hi;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_en;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_drain_cnt;
    logic              r_elig;
    logic [ADDR_W-1:0] r_best_bin;
    logic [SUM_W-1:0]  r_best_sum;
    logic [ADDR_W-1:0] r_peak_bin;
    logic [SUM_W-1:0]  r_peak_sum;
    logic              r_peak_valid;
    logic              r_tag_v    [RD_LAT];
    logic [ADDR_W-1:0] r_tag_addr [RD_LAT];

    logic              w_accept;
    logic              w_sample;
    logic [ADDR_W-1:0] w_sample_addr;
    logic              w_eligible;
    logic              w_take;
    logic [SUM_W-1:0]  w_sum_next;

    assign w_accept      = (r_state == IDLE) && start;
    assign w_sample      = r_tag_v[RD_LAT-1];
    assign w_sample_addr = r_tag_addr[RD_LAT-1];
    // Window is full once the sample address reaches lo + WIN_LEN - 1 (widened to avoid wrap).
    assign w_eligible    = w_sample &&
                           (ELIG_W'(w_sample_addr) >= ELIG_W'(r_lo) + ELIG_W'(WIN_LEN - 1));
    assign w_take        = w_eligible && (!r_elig || (w_sum_next > r_best_sum));

    window_sum #(
        .DATA_W  (DATA_W),
        .WIN_LEN (WIN_LEN)
    ) u_window_sum (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_accept),
        .i_valid    (w_sample),
        .i_data     (rd_data),
        .o_sum_next (w_sum_next)
    );

    // Tag pipeline mirrors the memory latency so each returned word knows its bin.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_v[i]    <= 1'b0;
                r_tag_addr[i] <= '0;
            end
        end else begin
            r_tag_v[0]    <= r_rd_en;
            r_tag_addr[0] <= r_rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_v[i]    <= r_tag_v[i-1];
                r_tag_addr[i] <= r_tag_addr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_lo         <= '0;
            r_hi         <= '0;
            r_rd_addr    <= '0;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_drain_cnt  <= '0;
            r_elig       <= 1'b0;
            r_best_bin   <= '0;
            r_best_sum   <= '0;
            r_peak_bin   <= '0;
            r_peak_sum   <= '0;
            r_peak_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_take) begin
                r_best_bin <= w_sample_addr;
                r_best_sum <= w_sum_next;
                r_elig     <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_lo        <= lo_bin;
                        r_hi        <= hi_bin;
                        r_best_bin  <= '0;
                        r_best_sum  <= '0;
                        r_elig      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_drain_cnt <= '0;
                        if (lo_bin > hi_bin) begin
                            r_state <= FINISH;
                        end else begin
                            r_state   <= ISSUE;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= lo_bin;
                        end
                    end
                end
                ISSUE: begin
                    if (r_rd_addr == r_hi) begin
                        r_rd_en <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == 2'(RD_LAT - 1)) begin
                        r_state <= FINISH;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    r_peak_bin   <= r_best_bin;
                    r_peak_sum   <= r_best_sum;
                    r_peak_valid <= r_elig;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign rd_addr    = r_rd_addr;
    assign rd_en      = r_rd_en;
    assign busy       = r_busy;
    assign done       = r_done;
    assign peak_bin   = r_peak_bin;
    assign peak_sum   = r_peak_sum;
    assign peak_valid = r_peak_valid;

endmodule

// File: tb/tb_fft_peak_finder.sv
// Bench for fft_peak_finder: two instances (WIN_LEN=2/RD_LAT=1 and WIN_LEN=4/RD_LAT=3) share one
// spectrum memory and one request stream; results are compared against a brute-force window search.
module tb_fft_peak_finder;

    localparam int DW     = 16;
    localparam int AW     = 10;
    localparam int NBINS  = 1 << AW;
    localparam int WIN_A  = 2;
    localparam int LAT_A  = 1;
    localparam int WIN_B  = 4;
    localparam int LAT_B  = 3;
    localparam int SUMW_A = DW + $clog2(WIN_A);
    localparam int SUMW_B = DW + $clog2(WIN_B);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] loBin;
    logic [AW-1:0] hiBin;
    logic [DW-1:0] mem [NBINS];

    logic [DW-1:0]     rdDataA, rdDataB;
    logic [AW-1:0]     rdAddrA, rdAddrB;
    logic              rdEnA, rdEnB, busyA, busyB, doneA, doneB, validA, validB;
    logic [AW-1:0]     binA, binB;
    logic [SUMW_A-1:0] sumA;
    logic [SUMW_B-1:0] sumB;

    int errors = 0;
    int checks = 0;
    int prevBin [2];
    longint prevSum [2];
    int prevVal [2];

    always #5 clk = ~clk;

    fft_peak_finder #(.DATA_W(DW), .ADDR_W(AW), .WIN_LEN(WIN_A), .RD_LAT(LAT_A)) dutA (
        .clk(clk), .rst(rst), .start(start), .lo_bin(loBin), .hi_bin(hiBin),
        .rd_data(rdDataA), .rd_addr(rdAddrA), .rd_en(rdEnA), .busy(busyA), .done(doneA),
        .peak_bin(binA), .peak_sum(sumA), .peak_valid(validA)
    );

    fft_peak_finder #(.DATA_W(DW), .ADDR_W(AW), .WIN_LEN(WIN_B), .RD_LAT(LAT_B)) dutB (
        .clk(clk), .rst(rst), .start(start), .lo_bin(loBin), .hi_bin(hiBin),
        .rd_data(rdDataB), .rd_addr(rdAddrB), .rd_en(rdEnB), .busy(busyB), .done(doneB),
        .peak_bin(binB), .peak_sum(sumB), .peak_valid(validB)
    );

    // Memory models: data appears RD_LAT cycles after the read; idle reads return garbage.
    logic [DW-1:0] pipeA;
    logic [DW-1:0] pipeB [LAT_B];
    always @(posedge clk) begin
        pipeA    <= rdEnA ? mem[rdAddrA] : DW'($urandom);
        pipeB[0] <= rdEnB ? mem[rdAddrB] : DW'($urandom);
        for (int i = 1; i < LAT_B; i++) pipeB[i] <= pipeB[i-1];
    end
    assign rdDataA = pipeA;
    assign rdDataB = pipeB[LAT_B-1];

    // Brute force: every full window inside [lo, hi], first strictly-greater sum wins.
    function automatic void refPeak(input int lo, input int hi, input int win,
                                    output int bin, output longint sum, output int valid);
        longint s;
        bin = 0; sum = 0; valid = 0;
        if (lo <= hi) begin
            for (int b = lo + win - 1; b <= hi; b++) begin
                s = 0;
                for (int k = 0; k < win; k++) s += longint'(mem[b-k]);
                if (valid == 0 || s > sum) begin
                    valid = 1; sum = s; bin = b;
                end
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input string name, input int lo, input int hi, input int midStart);
        int     expBin [2];
        longint expSum [2];
        int     expVal [2];
        int     expEdge [2];
        int     edgeSeen [2];
        int     dones [2];
        int     enCnt [2];
        int     addrOk [2];
        logic [63:0] gotBin [2];
        logic [63:0] gotSum [2];
        logic [63:0] gotVal [2];
        logic   obsDone [2];
        logic   obsEn [2];
        logic [AW-1:0] obsAddr [2];
        int n, lastEdge;
        string dn;

        refPeak(lo, hi, WIN_A, expBin[0], expSum[0], expVal[0]);
        refPeak(lo, hi, WIN_B, expBin[1], expSum[1], expVal[1]);
        n = (lo <= hi) ? hi - lo + 1 : 0;
        expEdge[0] = (lo <= hi) ? n + LAT_A + 1 : 1;
        expEdge[1] = (lo <= hi) ? n + LAT_B + 1 : 1;
        lastEdge = ((expEdge[0] > expEdge[1]) ? expEdge[0] : expEdge[1]) + 4;
        for (int d = 0; d < 2; d++) begin
            edgeSeen[d] = -1; dones[d] = 0; enCnt[d] = 0; addrOk[d] = 1;
            gotBin[d] = 'x; gotSum[d] = 'x; gotVal[d] = 'x;
        end

        @(negedge clk);
        start = 1'b1; loBin = AW'(lo); hiBin = AW'(hi);
        for (int e = 0; e <= lastEdge; e++) begin
            @(posedge clk); #1;
            start = (e == midStart);
            if (e == 0 || e == midStart) begin
                loBin = AW'($urandom_range(0, 3));
                hiBin = AW'($urandom_range(4, 8));
            end
            obsDone[0] = doneA; obsEn[0] = rdEnA; obsAddr[0] = rdAddrA;
            obsDone[1] = doneB; obsEn[1] = rdEnB; obsAddr[1] = rdAddrB;
            if (e == 1 && lo <= hi) begin
                checkOutput({name, " A held bin"}, 64'(binA), 64'(prevBin[0]));
                checkOutput({name, " B held sum"}, 64'(sumB), 64'(prevSum[1]));
            end
            for (int d = 0; d < 2; d++) begin
                if (obsEn[d]) begin
                    if (obsAddr[d] !== AW'(lo + enCnt[d])) addrOk[d] = 0;
                    enCnt[d]++;
                end
                if (obsDone[d]) begin
                    dones[d]++;
                    if (edgeSeen[d] < 0) begin
                        edgeSeen[d] = e;
                        gotBin[d] = (d == 0) ? 64'(binA)   : 64'(binB);
                        gotSum[d] = (d == 0) ? 64'(sumA)   : 64'(sumB);
                        gotVal[d] = (d == 0) ? 64'(validA) : 64'(validB);
                    end
                end
            end
        end
        start = 1'b0;

        for (int d = 0; d < 2; d++) begin
            dn = (d == 0) ? " A" : " B";
            checkOutput({name, dn, " done cycle"}, 64'(edgeSeen[d] + 1), 64'(expEdge[d] + 1));
            checkOutput({name, dn, " done count"}, 64'(dones[d]), 64'd1);
            checkOutput({name, dn, " peak_valid"}, gotVal[d], 64'(expVal[d]));
            checkOutput({name, dn, " peak_bin"},   gotBin[d], 64'(expBin[d]));
            checkOutput({name, dn, " peak_sum"},   gotSum[d], 64'(expSum[d]));
            checkOutput({name, dn, " reads"},      64'(enCnt[d]), 64'(n));
            checkOutput({name, dn, " addr seq"},   64'(addrOk[d]), 64'd1);
            prevBin[d] = expBin[d]; prevSum[d] = expSum[d]; prevVal[d] = expVal[d];
        end
    endtask

    task automatic checkIdleZero(input string name);
        checkOutput({name, " A busy"},  64'(busyA),  64'd0);
        checkOutput({name, " A rd_en"}, 64'(rdEnA),  64'd0);
        checkOutput({name, " A done"},  64'(doneA),  64'd0);
        checkOutput({name, " A valid"}, 64'(validA), 64'd0);
        checkOutput({name, " A bin"},   64'(binA),   64'd0);
        checkOutput({name, " A sum"},   64'(sumA),   64'd0);
        checkOutput({name, " A addr"},  64'(rdAddrA), 64'd0);
        checkOutput({name, " B busy"},  64'(busyB),  64'd0);
        checkOutput({name, " B rd_en"}, 64'(rdEnB),  64'd0);
        checkOutput({name, " B sum"},   64'(sumB),   64'd0);
        checkOutput({name, " B addr"},  64'(rdAddrB), 64'd0);
    endtask

    task automatic applyAbort();
        int stray = 0;
        @(negedge clk);
        start = 1'b1; loBin = '0; hiBin = AW'(NBINS - 1);
        for (int e = 0; e < 200; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (doneA || doneB) stray++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkIdleZero("abort");
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (doneA || doneB || busyA || busyB) stray++;
        end
        checkOutput("abort no done", 64'(stray), 64'd0);
        for (int d = 0; d < 2; d++) begin
            prevBin[d] = 0; prevSum[d] = 0; prevVal[d] = 0;
        end
    endtask

    task automatic fillMem(input int maxVal);
        for (int i = 0; i < NBINS; i++) mem[i] = DW'($urandom_range(0, maxVal));
    endtask

    task automatic clearMem();
        for (int i = 0; i < NBINS; i++) mem[i] = '0;
    endtask

    initial begin
        int lo, hi;
        rst = 1'b1; start = 1'b0; loBin = '0; hiBin = '0;
        for (int d = 0; d < 2; d++) begin
            prevBin[d] = 0; prevSum[d] = 0; prevVal[d] = 0;
        end
        clearMem();
        repeat (3) @(posedge clk);
        #1;
        checkIdleZero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NBINS; i++) mem[i] = DW'(i);
        applyStimulus("ramp", 0, NBINS - 1, 50);

        clearMem();
        mem[100] = 16'd500; mem[101] = 16'd300;
        applyStimulus("spike", 8, NBINS - 1, -1);

        clearMem();
        mem[50] = 16'd10; mem[51] = 16'd10; mem[60] = 16'd10; mem[61] = 16'd10;
        applyStimulus("tie", 0, NBINS - 1, -1);

        applyStimulus("single", 5, 5, -1);
        applyStimulus("inverted", 9, 3, -1);

        clearMem();
        for (int i = 500; i <= 503; i++) mem[i] = 16'd100;
        applyStimulus("block", 0, NBINS - 1, 300);

        applyAbort();
        clearMem();
        mem[100] = 16'd500; mem[101] = 16'd300;
        applyStimulus("post-abort", 8, NBINS - 1, -1);

        for (int r = 0; r < 6; r++) begin
            fillMem((r % 2 == 0) ? 3 : 65535);
            lo = $urandom_range(0, NBINS - 1);
            hi = lo + $urandom_range(0, 120);
            if (hi > NBINS - 1) hi = NBINS - 1;
            if (r == 4) begin
                hi = lo;
                lo = (hi < NBINS - 1) ? hi + 1 : hi - 1;
                if (lo < hi) begin
                    lo = hi; hi = lo - 1;
                end
            end
            applyStimulus($sformatf("rand%0d", r), lo, hi, (r == 3) ? 10 : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
